// File: rtl/video_timing_pkg.sv
// Shared constants and types for the 15 kHz test-timing generator.
// Holds default raster geometry, counter/colour widths, pattern-select
// encodings and the RGB payload struct.
package video_timing_pkg;

  localparam int unsigned HCNT_W  = 10;
  localparam int unsigned VCNT_W  = 9;
  localparam int unsigned COLOR_W = 6;
  localparam int unsigned FRAME_W = 8;

  // Default PAL-style geometry at a 12 MHz pixel clock
  localparam int unsigned DEF_H_ACTIVE = 512;
  localparam int unsigned DEF_H_FRONT  = 32;
  localparam int unsigned DEF_H_SYNC   = 56;
  localparam int unsigned DEF_H_BACK   = 168;
  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_V_FRONT  = 24;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BACK   = 45;

  localparam logic [COLOR_W-1:0] FULL_LEVEL = 6'h3F;
  localparam logic [COLOR_W-1:0] CHECK_BLUE = 6'h20;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_CHECK = 2'd3
  } pat_sel_e;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/video_test_timing_if.sv
// Video bundle between the timing generator (master) and its consumer (slave).
//   pattern_sel : pattern select, consumer -> generator
//   r/g/b       : 6-bit pixel colour
//   hsync_n, vsync_n, csync_n : active-low syncs
//   blank, frame_start        : blanking and frame-start strobe
//   hcnt, vcnt                : raw position counters
interface video_test_timing_if;
  import video_timing_pkg::*;

  logic [1:0]         pattern_sel;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               hsync_n;
  logic               vsync_n;
  logic               csync_n;
  logic               blank;
  logic               frame_start;
  logic [HCNT_W-1:0]  hcnt;
  logic [VCNT_W-1:0]  vcnt;

  modport master (
    input  pattern_sel,
    output r, g, b, hsync_n, vsync_n, csync_n, blank, frame_start, hcnt, vcnt
  );

  modport slave (
    output pattern_sel,
    input  r, g, b, hsync_n, vsync_n, csync_n, blank, frame_start, hcnt, vcnt
  );

endinterface

// File: rtl/test_pattern_gen.sv
// Maps raster position and frame phase to a registered 6-bit RGB pixel.
//   clkvideo, reset : pixel clock, async active-high reset
//   hcnt, vcnt      : current counter position
//   check_phase     : frame counter bit that flips the checkerboard
//   pat             : pattern in effect for this pixel
//   active          : position is inside the visible area
//   rgb             : registered pixel colour (zero when not active)
module test_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic              clkvideo,
  input  logic              reset,
  input  logic [HCNT_W-1:0] hcnt,
  input  logic [VCNT_W-1:0] vcnt,
  input  logic              check_phase,
  input  pat_sel_e          pat,
  input  logic              active,
  output rgb_t              rgb
);

  logic [2:0] bar_v;
  logic       grid_c;
  rgb_t       pix_c;

  // Pixel colour for the current position
  always_comb begin
    bar_v  = 3'd7 - hcnt[8:6];
    grid_c = (hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0) ||
             (hcnt == HCNT_W'(H_ACTIVE - 1)) || (vcnt == VCNT_W'(V_ACTIVE - 1));
    pix_c  = '0;
    case (pat)
      PAT_BARS: begin
        pix_c.g = bar_v[2] ? FULL_LEVEL : '0;
        pix_c.r = bar_v[1] ? FULL_LEVEL : '0;
        pix_c.b = bar_v[0] ? FULL_LEVEL : '0;
      end
      PAT_GRID: begin
        if (grid_c) pix_c = '{r: FULL_LEVEL, g: FULL_LEVEL, b: FULL_LEVEL};
      end
      PAT_RAMP: begin
        pix_c = '{r: hcnt[8:3], g: hcnt[8:3], b: hcnt[8:3]};
      end
      PAT_CHECK: begin
        if (hcnt[5] ^ vcnt[5] ^ check_phase)
          pix_c = '{r: FULL_LEVEL, g: FULL_LEVEL, b: FULL_LEVEL};
        else
          pix_c.b = CHECK_BLUE;
      end
      default: pix_c = '0;
    endcase
    if (!active) pix_c = '0;
  end

  // Output register
  always_ff @(posedge clkvideo or posedge reset) begin
    if (reset) rgb <= '0;
    else       rgb <= pix_c;
  end

endmodule

// File: rtl/video_test_timing.sv
// 15 kHz raster timing plus selectable test pattern for the core-test build.
//   clkvideo : 12 MHz pixel clock
//   reset    : asynchronous, active-high
//   vid      : master side of the video bundle (pattern_sel in; RGB, syncs,
//              blank, frame_start registered out; hcnt/vcnt are the live
//              counters)
module video_test_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK
) (
  input  logic                clkvideo,
  input  logic                reset,
  video_test_timing_if.master vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HCNT_W-1:0]  hcnt_q;
  logic [VCNT_W-1:0]  vcnt_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic               h_last_c;
  logic               v_last_c;
  logic               origin_c;
  logic               active_c;
  logic               hs_c;
  logic               vs_c;
  logic               hsync_n_q;
  logic               vsync_n_q;
  logic               csync_n_q;
  logic               blank_q;
  logic               frame_start_q;
  pat_sel_e           pat_q;
  pat_sel_e           pat_eff_c;
  rgb_t               rgb_q;

  assign h_last_c = (hcnt_q == HCNT_W'(H_TOTAL - 1));
  assign v_last_c = (vcnt_q == VCNT_W'(V_TOTAL - 1));
  assign origin_c = (hcnt_q == '0) && (vcnt_q == '0);
  assign active_c = (hcnt_q < HCNT_W'(H_ACTIVE)) && (vcnt_q < VCNT_W'(V_ACTIVE));
  assign hs_c     = (hcnt_q >= HCNT_W'(HS_START)) && (hcnt_q < HCNT_W'(HS_END));
  // vcnt only moves on the hcnt wrap, so vsync edges land on hcnt = 0
  assign vs_c     = (vcnt_q >= VCNT_W'(VS_START)) && (vcnt_q < VCNT_W'(VS_END));

  // The selection sampled at the origin applies to that very pixel, so a
  // whole frame is always drawn with a single pattern
  assign pat_eff_c = origin_c ? pat_sel_e'(vid.pattern_sel) : pat_q;

  // Free-running raster counters
  always_ff @(posedge clkvideo or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (h_last_c) begin
      hcnt_q <= '0;
      vcnt_q <= v_last_c ? '0 : vcnt_q + VCNT_W'(1);
    end else begin
      hcnt_q <= hcnt_q + HCNT_W'(1);
    end
  end

  // Registered syncs, blanking and frame strobe (one cycle behind counters)
  always_ff @(posedge clkvideo or posedge reset) begin
    if (reset) begin
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      csync_n_q     <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hsync_n_q     <= ~hs_c;
      vsync_n_q     <= ~vs_c;
      csync_n_q     <= ~(hs_c ^ vs_c);
      blank_q       <= ~active_c;
      frame_start_q <= origin_c;
    end
  end

  // Frame counter and per-frame pattern latch
  always_ff @(posedge clkvideo or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      pat_q       <= PAT_BARS;
    end else if (origin_c) begin
      frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
      pat_q       <= pat_eff_c;
    end
  end

  test_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .clkvideo    (clkvideo),
    .reset       (reset),
    .hcnt        (hcnt_q),
    .vcnt        (vcnt_q),
    .check_phase (frame_cnt_q[5]),
    .pat         (pat_eff_c),
    .active      (active_c),
    .rgb         (rgb_q)
  );

  assign vid.r           = rgb_q.r;
  assign vid.g           = rgb_q.g;
  assign vid.b           = rgb_q.b;
  assign vid.hsync_n     = hsync_n_q;
  assign vid.vsync_n     = vsync_n_q;
  assign vid.csync_n     = csync_n_q;
  assign vid.blank       = blank_q;
  assign vid.frame_start = frame_start_q;
  assign vid.hcnt        = hcnt_q;
  assign vid.vcnt        = vcnt_q;

endmodule

// File: tb/tb_video_test_timing.sv
// Bench for video_test_timing: two instances (full-width lines with few
// lines per frame, and a tiny raster for fast frame-counter wrap) checked
// every clock against an arithmetic reference model of the raster.
module tb_video_test_timing;
  import video_timing_pkg::*;

  localparam int AHA = 512, AHF = 32, AHS = 56, AHB = 168;
  localparam int AVA = 6,   AVF = 1,  AVS = 2,  AVB = 1;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  localparam int AFT = AHT * AVT;

  localparam int BHA = 8, BHF = 2, BHS = 3, BHB = 3;
  localparam int BVA = 4, BVF = 1, BVS = 2, BVB = 1;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;
  localparam int BFT = BHT * BVT;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs_n;
    logic       vs_n;
    logic       cs_n;
    logic       blank;
    logic       fs;
  } vo_t;

  localparam vo_t RST_V = {18'd0, 5'b11110};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  video_test_timing_if ifa ();
  video_test_timing_if ifb ();

  video_test_timing #(
    .H_ACTIVE(AHA), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
    .V_ACTIVE(AVA), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB)
  ) dut_a (.clkvideo(clk), .reset(rst), .vid(ifa));

  video_test_timing #(
    .H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_ACTIVE(BVA), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
  ) dut_b (.clkvideo(clk), .reset(rst), .vid(ifb));

  int checks = 0;
  int errors = 0;
  int n = 0;
  int ta = 0, tb = 0;
  int pa = 0, pb = 0;
  vo_t expa = RST_V, expb = RST_V;
  int hs_fall = -1, vs_fall = -1, fs_at = -1;
  bit fs_pend = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Expected registered outputs produced from raster state index t
  // (t = clocks since the counters last read (0,0) out of reset).
  function automatic vo_t model(input int ha, input int hf, input int hs, input int hb,
                                input int va, input int vf, input int vsl, input int vb,
                                input int t, input int pat);
    int  ht, vt, ft, h, v, fc, cv;
    bit  act, hsa, vsa, line;
    vo_t o;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vsl + vb;
    ft  = ht * vt;
    h   = t % ht;
    v   = (t / ht) % vt;
    fc  = ((t + ft - 1) / ft) % 256;
    act = (h < ha) && (v < va);
    hsa = (h >= ha + hf) && (h < ha + hf + hs);
    vsa = (v >= va + vf) && (v < va + vf + vsl);
    o   = '0;
    if (act) begin
      case (pat)
        0: begin
          cv  = 7 - ((h / 64) % 8);
          o.g = ((cv / 4) % 2 != 0) ? 6'h3F : 6'h00;
          o.r = ((cv / 2) % 2 != 0) ? 6'h3F : 6'h00;
          o.b = (cv % 2 != 0) ? 6'h3F : 6'h00;
        end
        1: begin
          line = (h % 32 == 0) || (v % 32 == 0) || (h == ha - 1) || (v == va - 1);
          if (line) begin o.r = 6'h3F; o.g = 6'h3F; o.b = 6'h3F; end
        end
        2: begin
          o.r = 6'((h / 8) % 64); o.g = o.r; o.b = o.r;
        end
        default: begin
          if (((h / 32) + (v / 32) + (fc / 32)) % 2 == 1) begin
            o.r = 6'h3F; o.g = 6'h3F; o.b = 6'h3F;
          end else begin
            o.b = 6'h20;
          end
        end
      endcase
    end
    o.hs_n  = !hsa;
    o.vs_n  = !vsa;
    o.cs_n  = (hsa == vsa);
    o.blank = !act;
    o.fs    = (t % ft == 0);
    return o;
  endfunction

  function automatic vo_t grab_a();
    return {ifa.r, ifa.g, ifa.b, ifa.hsync_n, ifa.vsync_n, ifa.csync_n, ifa.blank, ifa.frame_start};
  endfunction

  function automatic vo_t grab_b();
    return {ifb.r, ifb.g, ifb.b, ifb.hsync_n, ifb.vsync_n, ifb.csync_n, ifb.blank, ifb.frame_start};
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, "A.out"},  32'(grab_a()), 32'(expa));
    chk({pfx, "A.hcnt"}, 32'(ifa.hcnt), 32'(ta % AHT));
    chk({pfx, "A.vcnt"}, 32'(ifa.vcnt), 32'((ta / AHT) % AVT));
    chk({pfx, "B.out"},  32'(grab_b()), 32'(expb));
    chk({pfx, "B.hcnt"}, 32'(ifb.hcnt), 32'(tb % BHT));
    chk({pfx, "B.vcnt"}, 32'(ifb.vcnt), 32'((tb / BHT) % BVT));
  endtask

  task automatic clear_track();
    hs_fall = -1; vs_fall = -1; fs_at = -1; fs_pend = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  // Sync period/width measurements on instance A
  task automatic track_a();
    if (prev_hs && !ifa.hsync_n) begin
      if (hs_fall >= 0) chk("A.hs_period", 32'(n - hs_fall), 32'(AHT));
      if (fs_pend) begin
        chk("A.hs_after_fs", 32'(n - fs_at), 32'(AHA + AHF));
        fs_pend = 0;
      end
      hs_fall = n;
    end
    if (!prev_hs && ifa.hsync_n && hs_fall >= 0) chk("A.hs_width", 32'(n - hs_fall), 32'(AHS));
    if (prev_vs && !ifa.vsync_n) begin
      if (vs_fall >= 0) chk("A.vs_period", 32'(n - vs_fall), 32'(AFT));
      vs_fall = n;
    end
    if (!prev_vs && ifa.vsync_n && vs_fall >= 0) chk("A.vs_width", 32'(n - vs_fall), 32'(AVS * AHT));
    if (ifa.frame_start) begin
      if (fs_at >= 0) chk("A.fs_period", 32'(n - fs_at), 32'(AFT));
      fs_at = n;
      fs_pend = 1;
    end
    prev_hs = ifa.hsync_n;
    prev_vs = ifa.vsync_n;
  endtask

  // One clock: check last edge's results, set inputs/reset, advance the model
  task automatic cycle(input bit do_rst, input bit rand_a, input bit rand_b);
    @(negedge clk);
    check_all("");
    if (!rst) track_a();
    n++;
    if (rand_a && $urandom_range(0, 511) == 0) ifa.pattern_sel = 2'($urandom_range(0, 3));
    if (rand_b && $urandom_range(0, 63) == 0)  ifb.pattern_sel = 2'($urandom_range(0, 3));
    if (do_rst && !rst) begin
      rst = 1'b1;
      #1;
      ta = 0; tb = 0; expa = RST_V; expb = RST_V;
      check_all("async_rst.");
    end
    rst = do_rst;
    if (rst) begin
      ta = 0; tb = 0; expa = RST_V; expb = RST_V;
      clear_track();
    end else begin
      if (ta % AFT == 0) pa = int'(ifa.pattern_sel);
      if (tb % BFT == 0) pb = int'(ifb.pattern_sel);
      expa = model(AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, ta, pa);
      expb = model(BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, tb, pb);
      ta++;
      tb++;
    end
  endtask

  initial begin
    ifa.pattern_sel = 2'd0;
    ifb.pattern_sel = 2'd3;
    #1 rst = 1'b1;
    #1 check_all("reset.");
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // Colour bars on A, checkerboard on B
    repeat (2 * AFT) cycle(1'b0, 1'b0, 1'b0);

    // Grid, switched to ramp mid-frame at line 3
    ifa.pattern_sel = 2'd1;
    cycle(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < AFT && (ta % AFT) != 3 * AHT; k++) cycle(1'b0, 1'b0, 1'b0);
    ifa.pattern_sel = 2'd2;
    repeat (2 * AFT) cycle(1'b0, 1'b0, 1'b0);

    // Random pattern changes
    repeat (AFT) cycle(1'b0, 1'b1, 1'b0);
    repeat (20 * BFT) cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-frame at A's (300, 3), then run past the next frame
    for (int k = 0; k < AFT && (ta % AFT) != 3 * AHT + 300; k++) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_pos", 32'(ta % AFT), 32'(3 * AHT + 300));
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    repeat (AFT + 100) cycle(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_all("final.");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
